// File: rtl/oct_mac_pkg.sv
// Shared definitions for the OctMAC weight path: feeder FSM state encoding and default widths.
package oct_mac_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_PARA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } feed_state_t;

endpackage

// File: rtl/weight_skid_buf.sv
// Two-entry FIFO between the scratch pad read port and the PE handshake; head is always the oldest entry.
module weight_skid_buf
  import oct_mac_pkg::*;
#(
  parameter int WIDTH = DEF_DATA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] entry1;

  // Head only changes on a pop or when filling an empty buffer, so it stays stable while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head   <= '0;
      entry1 <= '0;
      count  <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) head <= push_data;
          else entry1 <= push_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          head  <= entry1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            head <= push_data;
          end else begin
            head   <= entry1;
            entry1 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/weight_feeder.sv
// Streams weights from the scratch pad to the PE array, replaying the filter once per pixel.
// Optional pe_weight_last output is enabled with `define FEED_LAST_FLAG_EN.
module weight_feeder
  import oct_mac_pkg::*;
#(
  parameter int DATA_WIDTH         = DEF_DATA_WIDTH,
  parameter int PARA_WIDTH         = DEF_PARA_WIDTH,
  parameter int ADDRESSWIDTH_W_PAD = DEF_ADDR_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          feed_start,
  input  logic [PARA_WIDTH-1:0]         weight_num,
  input  logic [PARA_WIDTH-1:0]         pixel_num,
  input  logic [ADDRESSWIDTH_W_PAD-1:0] wr_count,
  input  logic                          load_done,
  output logic [ADDRESSWIDTH_W_PAD-1:0] raddr,
  input  logic [DATA_WIDTH-1:0]         weight_rd,
  output logic [DATA_WIDTH-1:0]         pe_weight,
  output logic                          pe_weight_valid,
`ifdef FEED_LAST_FLAG_EN
  output logic                          pe_weight_last,
`endif
  input  logic                          pe_ready,
  output logic                          busy,
  output logic                          feed_done
);

  feed_state_t state, state_next;

  logic [PARA_WIDTH-1:0] wn_r, pn_r, w_idx, pass;
  logic                  rd_pending;
  logic [1:0]            buf_count;
  logic [2:0]            occupancy;
  logic                  pop, accept, last_w, last_read, avail, credit, issue;

  assign pop       = pe_weight_valid & pe_ready;
  assign accept    = feed_start & (state == IDLE) & ~busy;
  assign last_w    = (w_idx == (wn_r - PARA_WIDTH'(1)));
  assign last_read = last_w & (pass == (pn_r - PARA_WIDTH'(1)));

  // Pass 0 may only read what the loader has already written; later passes reread a complete pad.
  assign avail     = (pass != '0) | load_done | (ADDRESSWIDTH_W_PAD'(w_idx) < wr_count);
  assign occupancy = {1'b0, buf_count} + {2'b00, rd_pending} - {2'b00, pop};
  assign credit    = (occupancy < 3'd2);
  assign issue     = (state == RUN) & avail & credit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = ((weight_num == '0) || (pixel_num == '0)) ? DONE : RUN;
      RUN:     if (issue && last_read) state_next = DRAIN;
      DRAIN:   if ((buf_count == 2'd0) && !rd_pending) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // busy stays up through the feed_done cycle so a start arriving alongside the pulse is ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wn_r       <= '0;
      pn_r       <= '0;
      w_idx      <= '0;
      pass       <= '0;
      raddr      <= '0;
      rd_pending <= 1'b0;
      busy       <= 1'b0;
      feed_done  <= 1'b0;
    end else begin
      feed_done  <= (state == DONE);
      rd_pending <= issue;
      if (accept) begin
        busy  <= 1'b1;
        wn_r  <= weight_num;
        pn_r  <= pixel_num;
        w_idx <= '0;
        pass  <= '0;
      end else if (feed_done) begin
        busy <= 1'b0;
      end
      if (issue) begin
        raddr <= ADDRESSWIDTH_W_PAD'(w_idx);
        if (last_w) begin
          w_idx <= '0;
          pass  <= pass + PARA_WIDTH'(1);
        end else begin
          w_idx <= w_idx + PARA_WIDTH'(1);
        end
      end
    end
  end

`ifdef FEED_LAST_FLAG_EN
  logic                rd_last;
  logic [DATA_WIDTH:0] head;

  // The last flag rides alongside its read so it leaves the buffer with the matching weight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_last <= 1'b0;
    else if (issue) rd_last <= last_w;
  end

  weight_skid_buf #(.WIDTH(DATA_WIDTH + 1)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (rd_pending),
    .push_data ({rd_last, weight_rd}),
    .pop       (pop),
    .head      (head),
    .count     (buf_count)
  );

  assign pe_weight      = head[DATA_WIDTH-1:0];
  assign pe_weight_last = head[DATA_WIDTH] & pe_weight_valid;
`else
  weight_skid_buf #(.WIDTH(DATA_WIDTH)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (rd_pending),
    .push_data (weight_rd),
    .pop       (pop),
    .head      (pe_weight),
    .count     (buf_count)
  );
`endif

  assign pe_weight_valid = (buf_count != 2'd0);

endmodule
